// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg -- shared definitions for the ROM download controller.
//
// Contents:
//   dl_state_e    controller FSM states (NOROM, LOAD, HOLD, RUN)
//   DL_INDEX_ROM  data_io slot that carries the game ROM image
//   DN_ADDR_W     width of the ROM write address to the game core
package rom_dl_pkg;

    typedef enum logic [1:0] {
        ST_NOROM = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } dl_state_e;

    localparam logic [7:0] DL_INDEX_ROM = 8'd0;
    localparam int unsigned DN_ADDR_W   = 16;

endpackage : rom_dl_pkg

// File: rtl/rom_dl_ctrl_rst_hold_cnt.sv
// rst_hold_cnt -- loadable down-counter with a zero flag.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (wins over counting)
//   load_val in   W  value loaded on load
//   zero     out  count is zero
//
// When not loading, the count decrements until it reaches zero and stays there.
module rst_hold_cnt #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule : rst_hold_cnt

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl -- sits between data_io and the game core: forwards ROM image
// bytes, keeps the core in reset while there is no ROM or a download is in
// flight, and reports size/overflow/checksum status for the last index-0 image.
//
// Build option: define ROM_DL_CHECKSUM_EN to build the byte-sum accumulator;
// without it checksum is tied to 8'h00.
//
// Ports:
//   clk_sys, reset            clock; asynchronous active-high reset
//   ioctl_download/index/wr/addr/dout   data_io download interface
//   user_reset                OSD or button reset, level
//   dn_addr/dn_data/dn_wr     ROM write port to the game core
//   core_reset                registered game core reset
//   rom_loaded/size_ok/addr_ovf/dl_bytes/checksum   download status
//   state_dbg                 current FSM state
//
// Strobe semantics: ioctl_wr is a one-cycle byte-valid with no back-pressure;
// the byte is consumed in that cycle if accepted, and dn_wr is a one-cycle
// valid one clock later with dn_addr/dn_data held until the next byte.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter logic [16:0] EXPECT_BYTES = 17'h10000,
    parameter int unsigned HOLD_CYCLES  = 1024
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 user_reset,
    output logic [DN_ADDR_W-1:0] dn_addr,
    output logic [7:0]           dn_data,
    output logic                 dn_wr,
    output logic                 core_reset,
    output logic                 rom_loaded,
    output logic                 size_ok,
    output logic                 addr_ovf,
    output logic [16:0]          dl_bytes,
    output logic [7:0]           checksum,
    output dl_state_e            state_dbg
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    dl_state_e            state_q, state_d;
    logic                 dl_prev_q;
    logic                 idx0_q, idx0_d;
    logic                 core_reset_q, core_reset_d;
    logic                 rom_loaded_q, rom_loaded_d;
    logic                 size_ok_q, size_ok_d;
    logic                 addr_ovf_q, addr_ovf_d;
    logic [16:0]          dl_bytes_q, dl_bytes_d;
    logic                 dn_wr_q, dn_wr_d;
    logic [DN_ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]           dn_data_q, dn_data_d;
    logic                 cnt_load, cnt_zero;
    logic                 dl_rise, dl_fall, is_rom_idx, strobe_rom, accept, ovf_hit;

    assign is_rom_idx = (ioctl_index == DL_INDEX_ROM);
    assign dl_rise    = ioctl_download & ~dl_prev_q;
    assign dl_fall    = ~ioctl_download & dl_prev_q;
    assign strobe_rom = ioctl_wr & ioctl_download & is_rom_idx;
    // The ROM window is 64 KiB; anything above it is dropped and flagged.
    assign accept     = strobe_rom & (ioctl_addr[24:16] == '0);
    assign ovf_hit    = strobe_rom & (ioctl_addr[24:16] != '0);

    rst_hold_cnt #(.W(CNT_W)) u_hold_cnt (
        .clk      (clk_sys),
        .rst      (reset),
        .load     (cnt_load),
        .load_val (HOLD_LOAD),
        .zero     (cnt_zero)
    );

    // FSM. A new download always wins, including over user_reset in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        case (state_q)
            ST_NOROM: if (dl_rise) state_d = ST_LOAD;
            ST_LOAD: begin
                if (dl_fall) begin
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (dl_rise) begin
                    state_d = ST_LOAD;
                end else if (cnt_zero && !rom_loaded_q) begin
                    state_d = ST_NOROM;
                end else if (user_reset) begin
                    // Restart the hold so release is timed from user_reset falling.
                    cnt_load = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dl_rise) begin
                    state_d = ST_LOAD;
                end else if (user_reset) begin
                    state_d  = ST_HOLD;
                    cnt_load = 1'b1;
                end
            end
            default: state_d = ST_NOROM;
        endcase
        // Registered from the current state: releases one clock after RUN is entered.
        core_reset_d = (state_q != ST_RUN);
    end

    // Download bookkeeping and the write port.
    always_comb begin
        idx0_d       = idx0_q;
        rom_loaded_d = rom_loaded_q;
        size_ok_d    = size_ok_q;
        addr_ovf_d   = addr_ovf_q;
        dl_bytes_d   = dl_bytes_q;
        dn_wr_d      = accept;
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;

        if (dl_rise) begin
            idx0_d = is_rom_idx;
            if (is_rom_idx) begin
                dl_bytes_d = '0;
                addr_ovf_d = 1'b0;
            end
        end
        if (accept) begin
            dn_addr_d = ioctl_addr[DN_ADDR_W-1:0];
            dn_data_d = ioctl_dout;
            if (dl_bytes_d != 17'h1FFFF) dl_bytes_d = dl_bytes_d + 17'd1;
        end
        if (ovf_hit) addr_ovf_d = 1'b1;
        // Uses the already-updated next values so a same-cycle byte is counted.
        if (dl_fall && idx0_q) begin
            rom_loaded_d = 1'b1;
            size_ok_d    = (dl_bytes_d == EXPECT_BYTES) && !addr_ovf_d;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= ST_NOROM;
            dl_prev_q    <= 1'b0;
            idx0_q       <= 1'b0;
            core_reset_q <= 1'b1;
            rom_loaded_q <= 1'b0;
            size_ok_q    <= 1'b0;
            addr_ovf_q   <= 1'b0;
            dl_bytes_q   <= '0;
            dn_wr_q      <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            dl_prev_q    <= ioctl_download;
            idx0_q       <= idx0_d;
            core_reset_q <= core_reset_d;
            rom_loaded_q <= rom_loaded_d;
            size_ok_q    <= size_ok_d;
            addr_ovf_q   <= addr_ovf_d;
            dl_bytes_q   <= dl_bytes_d;
            dn_wr_q      <= dn_wr_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (dl_rise && is_rom_idx) checksum_d = '0;
        if (accept) checksum_d = checksum_d + ioctl_dout;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = core_reset_q;
    assign rom_loaded = rom_loaded_q;
    assign size_ok    = size_ok_q;
    assign addr_ovf   = addr_ovf_q;
    assign dl_bytes   = dl_bytes_q;
    assign state_dbg  = state_q;

endmodule : rom_dl_ctrl

// File: doc/rom_dl_ctrl.md
ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Interface
REQ-001 Parameter EXPECT_BYTES, default 17'h10000: byte count for a complete index-0 ROM image.
REQ-002 Parameter HOLD_CYCLES, default 1024: minimum core_reset width in clk_sys cycles after a release condition.
REQ-003 Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high.
- ioctl_download  in  1  download-in-progress flag from data_io.
- ioctl_index  in  8  download slot.
- ioctl_wr  in  1  byte-valid strobe, one cycle wide.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- user_reset  in  1  OSD reset OR button reset, level.
- dn_addr  out  16  ROM write address to the game core.
- dn_data  out  8  ROM write data.
- dn_wr  out  1  ROM write strobe.
- core_reset  out  1  game core reset, level.
- rom_loaded  out  1  at least one index-0 download has completed.
- size_ok  out  1  last index-0 download wrote exactly EXPECT_BYTES bytes.
- addr_ovf  out  1  last index-0 download contained an address at or above 0x10000.
- dl_bytes  out  17  accepted-byte count of the current or last index-0 download.
- checksum  out  8  8-bit modular sum of accepted bytes (see Configuration).

Function
REQ-004 Four-state FSM: NOROM, LOAD, HOLD, RUN.
REQ-005 NOROM: core_reset=1. ioctl_download rising edge -> LOAD.
REQ-006 LOAD: core_reset=1. ioctl_download falling edge -> HOLD.
REQ-007 HOLD: core_reset=1; counter loads HOLD_CYCLES-1 on entry and counts down.
- Count 0 with rom_loaded=1 and user_reset=0 -> RUN.
- Count 0 with rom_loaded=0 -> NOROM.
REQ-008 RUN: core_reset=0.
- ioctl_download rising edge -> LOAD.
- user_reset=1 -> HOLD.
REQ-009 user_reset=1 in HOLD reloads the counter every cycle; core_reset therefore stays high for HOLD_CYCLES cycles after user_reset falls.
REQ-010 core_reset is a registered output; it deasserts on the first clock after RUN is entered.
REQ-011 Accepted byte: ioctl_wr=1 and ioctl_download=1 and ioctl_index=0 and ioctl_addr[24:16]=0.
REQ-012 On each accepted byte, one cycle later:
- dn_wr=1 for exactly one cycle.
- dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout.
- dn_addr and dn_data hold their values until the next accepted byte.
REQ-013 Write strobes with nonzero ioctl_index produce no dn_wr and leave the counters unchanged. Downloads with nonzero index still pass through LOAD and HOLD, so they still reset the core.
REQ-014 An index-0 strobe with ioctl_addr[24:16]!=0 is suppressed and sets addr_ovf.
REQ-015 ioctl_download rising edge with ioctl_index=0 clears dl_bytes, checksum and addr_ovf.
REQ-016 dl_bytes increments on each accepted byte and saturates at 17'h1FFFF.
REQ-017 On the falling edge of an index-0 download:
- rom_loaded is set to 1.
- size_ok is set to (dl_bytes==EXPECT_BYTES and addr_ovf==0), computed including a byte accepted in the same cycle.
REQ-018 rom_loaded stays set until reset, including across later downloads.
REQ-019 A short or oversized image still sets rom_loaded and reaches RUN; it is flagged by size_ok=0.
REQ-020 A download rising edge in HOLD -> LOAD.
REQ-021 Simultaneous user_reset and download rising edge in RUN -> LOAD; the download has priority.

Reset
REQ-022 Asynchronous reset forces the following values, independent of clk_sys:
- state=NOROM, core_reset=1, rom_loaded=0, size_ok=0, addr_ovf=0.
- dl_bytes=0, checksum=0, dn_wr=0, dn_addr=0, dn_data=0, counter=0.
- download edge-detect register=0.
REQ-023 Asserting reset during LOAD discards the partial download; the next download edge is detected afresh.

Configuration
REQ-024 With ROM_DL_CHECKSUM_EN defined: checksum accumulates the mod-256 sum of accepted bytes.
REQ-025 With ROM_DL_CHECKSUM_EN undefined:
- The accumulator is not built.
- checksum is tied to 8'h00.
- All other behaviour is identical.

Structure
REQ-026 A shared package rom_dl_pkg holds:
- the FSM state enum (NOROM, LOAD, HOLD, RUN);
- DL_INDEX_ROM=8'd0;
- DN_ADDR_W=16.
REQ-027 One sub-module, rst_hold_cnt: a loadable down-counter with a zero flag. All other logic is implemented inline.

Verification
REQ-028 Download index 0, 65536 bytes of value 8'h01 at addresses 0..0xFFFF, one strobe every 4 cycles -> required response:
- 65536 dn_wr pulses, each 1 cycle after its strobe.
- dl_bytes=0x10000, size_ok=1, rom_loaded=1.
- checksum=8'h00 with macro defined.
- core_reset falls exactly HOLD_CYCLES+1 cycles after ioctl_download falls.
REQ-029 Download index 0 of 100 bytes -> required response:
- rom_loaded=1, size_ok=0, dl_bytes=100.
- Core reaches RUN.
REQ-030 In RUN, download index 3 of 10 bytes -> required response:
- No dn_wr pulses; dl_bytes unchanged.
- core_reset=1 from the cycle after the rising edge until HOLD expires.
REQ-031 Index-0 strobe at ioctl_addr=25'h010000 inside a full image -> required response:
- The strobe produces no dn_wr.
- addr_ovf=1 and size_ok=0.
REQ-032 In RUN, pulse user_reset for 3 cycles, then assert it for 2000 cycles -> required response:
- core_reset rises and stays high for HOLD_CYCLES cycles after each deassertion of user_reset.
REQ-033 Assert reset mid-LOAD -> required response:
- All outputs return to their reset values immediately.
- A new complete download then behaves as in REQ-028.
